// File: rtl/nano_rv32i_pkg.sv
// nano_rv32i_pkg: shared widths, ALU op codes, operand-select constants and the issue entry type
package nano_rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              a_sel;
        logic              b_sel;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
    } issue_entry_t;

endpackage

// File: rtl/issue_operand_patch.sv
// issue_operand_patch: replaces register operands of an entry with a matching write-back result.
// With ALU_ISSUE_WB_PATCH_EN undefined the entry passes through untouched and wb_* are ignored.
module issue_operand_patch
    import nano_rv32i_pkg::*;
(
    input  issue_entry_t      entry,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output issue_entry_t      patched
);

`ifdef ALU_ISSUE_WB_PATCH_EN
    logic wb_live;
    logic a_hit;
    logic b_hit;

    assign wb_live = wb_we && (wb_rd != '0);
    assign a_hit   = wb_live && (entry.a_sel == A_SEL_RS1) && (entry.rs1 == wb_rd);
    assign b_hit   = wb_live && (entry.b_sel == B_SEL_RS2) && (entry.rs2 == wb_rd);

    // Swap in write-back data only for register-sourced operands; x0, PC and imm stay as they are
    always_comb begin
        patched   = entry;
        patched.a = a_hit ? wb_data : entry.a;
        patched.b = b_hit ? wb_data : entry.b;
    end
`else
    logic wb_unused;

    assign wb_unused = ^{wb_we, wb_rd, wb_data};
    assign patched   = entry;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry (head + skid) issue buffer ahead of the ALU with operand select and
// write-back patching; patching is built only when ALU_ISSUE_WB_PATCH_EN is defined.
module alu_issue_stage
    import nano_rv32i_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_AW-1:0] in_rs1_i,
    input  logic [REG_AW-1:0] in_rs2_i,
    input  logic [XLEN-1:0]   in_rs1_val_i,
    input  logic [XLEN-1:0]   in_rs2_val_i,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [XLEN-1:0]   in_imm_i,
    input  logic              in_a_sel_i,
    input  logic              in_b_sel_i,
    input  logic [2:0]        in_alu_op_i,
    input  logic [REG_AW-1:0] in_rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic [2:0]        alu_op_o,
    output logic [REG_AW-1:0] rd_o
);

    issue_entry_t head_q, skid_q, cap, cap_p, head_p, skid_p, head_d, skid_d;
    logic         ready_q;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid_i && ready_q;
    assign out_fire = head_q.valid && out_ready_i;

    assign cap = '{valid: 1'b1, op: in_alu_op_i, rd: in_rd_i, rs1: in_rs1_i, rs2: in_rs2_i,
                   a_sel: in_a_sel_i, b_sel: in_b_sel_i,
                   a: (in_a_sel_i == A_SEL_PC) ? in_pc_i : in_rs1_val_i,
                   b: (in_b_sel_i == B_SEL_IMM) ? in_imm_i : in_rs2_val_i};

    issue_operand_patch u_patch_cap  (.entry(cap),    .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched(cap_p));
    issue_operand_patch u_patch_head (.entry(head_q), .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched(head_p));
    issue_operand_patch u_patch_skid (.entry(skid_q), .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched(skid_p));

    // Refill the head from skid (older) or the incoming op when it frees up; otherwise park input in skid
    always_comb begin
        head_d = head_p;
        skid_d = skid_p;
        if (!head_q.valid || out_fire) begin
            head_d       = skid_q.valid ? skid_p : (in_fire ? cap_p : head_p);
            head_d.valid = skid_q.valid || in_fire;
            skid_d.valid = 1'b0;
        end else if (in_fire) begin
            skid_d = cap_p;
        end
    end

    // Entry registers; reset and flush empty both entries, ready mirrors the next skid occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
        ready_q <= !rst_i && (flush_i || !skid_d.valid);
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = head_q.valid;
    assign a_o         = head_q.a;
    assign b_o         = head_q.b;
    assign alu_op_o    = head_q.op;
    assign rd_o        = head_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based model of the issue stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [4:0]  in_rs1_i = '0;
    logic [4:0]  in_rs2_i = '0;
    logic [31:0] in_rs1_val_i = '0;
    logic [31:0] in_rs2_val_i = '0;
    logic [31:0] in_pc_i = '0;
    logic [31:0] in_imm_i = '0;
    logic        in_a_sel_i = 1'b0;
    logic        in_b_sel_i = 1'b0;
    logic [2:0]  in_alu_op_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  alu_op_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t q[$];

    alu_issue_stage dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rs1_val_i(in_rs1_val_i),
        .in_rs2_val_i(in_rs2_val_i), .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
        .in_a_sel_i(in_a_sel_i), .in_b_sel_i(in_b_sel_i), .in_alu_op_i(in_alu_op_i),
        .in_rd_i(in_rd_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .a_o(a_o), .b_o(b_o), .alu_op_o(alu_op_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A write-back overrides a register operand that names the same non-zero register
    function automatic op_t patch(input op_t e);
        op_t r = e;
`ifdef ALU_ISSUE_WB_PATCH_EN
        if (wb_we_i && wb_rd_i != 5'd0) begin
            if (!e.a_sel && e.rs1 == wb_rd_i) r.a = wb_data_i;
            if (!e.b_sel && e.rs2 == wb_rd_i) r.b = wb_data_i;
        end
`endif
        return r;
    endfunction

    // Model: in-order queue of ops held by the stage; sampled 1 time unit before each rising edge
    initial begin
        logic ready_exp = 1'b0;
        bit   have_exp = 1'b0;
        op_t  c;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #4;
            if (have_exp) chk("in_ready", {31'd0, in_ready_o}, {31'd0, ready_exp});
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, q.size() != 0});
            if (out_valid_o && q.size() > 0) begin
                chk("a_o", a_o, q[0].a);
                chk("b_o", b_o, q[0].b);
                chk("alu_op_o", {29'd0, alu_op_o}, {29'd0, q[0].op});
                chk("rd_o", {27'd0, rd_o}, {27'd0, q[0].rd});
            end
            if (rst_i || flush_i) begin
                q.delete();
                ready_exp = !rst_i;
            end else begin
                if (out_valid_o && out_ready_i && q.size() > 0) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) q[i] = patch(q[i]);
                if (in_valid_i && in_ready_o) begin
                    c = '{op: in_alu_op_i, rd: in_rd_i, rs1: in_rs1_i, rs2: in_rs2_i,
                          a_sel: in_a_sel_i, b_sel: in_b_sel_i,
                          a: in_a_sel_i ? in_pc_i : in_rs1_val_i,
                          b: in_b_sel_i ? in_imm_i : in_rs2_val_i};
                    q.push_back(patch(c));
                end
                ready_exp = q.size() < 2;
            end
            have_exp = 1'b1;
        end
    end

    task automatic set_op(input logic [4:0] rs1, input logic [31:0] v1, input logic [4:0] rs2,
                          input logic [31:0] v2, input logic a_sel, input logic b_sel,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] op,
                          input logic [4:0] rd);
        in_valid_i = 1'b1; in_rs1_i = rs1; in_rs1_val_i = v1; in_rs2_i = rs2; in_rs2_val_i = v2;
        in_a_sel_i = a_sel; in_b_sel_i = b_sel; in_pc_i = pc; in_imm_i = imm;
        in_alu_op_i = op; in_rd_i = rd;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we_i = we; wb_rd_i = rd; wb_data_i = data;
    endtask

    initial begin
        int sent = 0;
        int cyc = 0;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset_a_o", a_o, 32'd0);
        chk("reset_b_o", b_o, 32'd0);
        chk("reset_op_rd", {24'd0, alu_op_o, rd_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready_o}, 32'd1);

        out_ready_i = 1'b1;
        set_op(5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 1'b0, 32'h100, 32'h0, 3'b000, 5'd9);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("single_valid", {31'd0, out_valid_o}, 32'd1);
        chk("single_a", a_o, 32'd5);
        chk("single_b", b_o, 32'd7);
        chk("single_op", {29'd0, alu_op_o}, 32'd0);
        @(negedge clk);
        chk("single_drop", {31'd0, out_valid_o}, 32'd0);

        out_ready_i = 1'b0;
        set_op(5'd1, 32'd11, 5'd2, 32'd12, 1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 5'd1);
        @(negedge clk);
        set_op(5'd1, 32'd21, 5'd2, 32'd22, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 5'd2);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("skid_full_ready", {31'd0, in_ready_o}, 32'd0);
        chk("stall_head_x", {27'd0, rd_o}, 32'd1);
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("drain_y", {27'd0, rd_o}, 32'd2);
        chk("drain_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk);
        chk("drain_empty", {31'd0, out_valid_o}, 32'd0);

        out_ready_i = 1'b0;
        set_op(5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd3);
        @(negedge clk);
        in_valid_i = 1'b0;
        set_wb(1'b1, 5'd6, 32'hDEAD);
        @(negedge clk);
        set_wb(1'b0, 5'd0, 32'h0);
`ifdef ALU_ISSUE_WB_PATCH_EN
        exp_a = 32'hDEAD;
`else
        exp_a = 32'd1;
`endif
        chk("held_patch_a", a_o, exp_a);
        out_ready_i = 1'b1;
        @(negedge clk);

        set_op(5'd1, 32'd3, 5'd0, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0, 3'b011, 5'd4);
        set_wb(1'b1, 5'd0, 32'd9);
        @(negedge clk);
        chk("x0_no_patch", b_o, 32'h22);
        set_op(5'd1, 32'd3, 5'd5, 32'h33, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 3'b100, 5'd5);
        set_wb(1'b1, 5'd5, 32'h77);
        @(negedge clk);
        chk("imm_no_patch", b_o, 32'hFFFFFFF0);
        set_op(5'd1, 32'd3, 5'd5, 32'h11, 1'b1, 1'b0, 32'h40, 32'h0, 3'b101, 5'd6);
        set_wb(1'b1, 5'd5, 32'h77);
        @(negedge clk);
`ifdef ALU_ISSUE_WB_PATCH_EN
        exp_b = 32'h77;
`else
        exp_b = 32'h11;
`endif
        chk("capture_patch_b", b_o, exp_b);
        chk("pc_select_a", a_o, 32'h40);
        in_valid_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        @(negedge clk);

        out_ready_i = 1'b0;
        set_op(5'd2, 32'd1, 5'd3, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0, 3'b110, 5'd7);
        @(negedge clk);
        set_op(5'd2, 32'd4, 5'd3, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0, 3'b111, 5'd8);
        @(negedge clk);
        set_op(5'd2, 32'd6, 5'd3, 32'd7, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd10);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_full_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_full_ready", {31'd0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_nothing_later", {31'd0, out_valid_o}, 32'd0);

        out_ready_i = 1'b0;
        set_op(5'd2, 32'd1, 5'd3, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 5'd11);
        @(negedge clk);
        set_op(5'd2, 32'd9, 5'd3, 32'd9, 1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 5'd12);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_drops_input", {31'd0, out_valid_o}, 32'd0);

        set_op(5'd2, 32'd1, 5'd3, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 5'd13);
        @(negedge clk);
        set_op(5'd2, 32'd1, 5'd3, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 5'd14);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midreset_valid", {31'd0, out_valid_o}, 32'd0);
        chk("midreset_ready", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk);
        chk("midreset_ready_after", {31'd0, in_ready_o}, 32'd1);

        while (sent < 100 && cyc < 3000) begin
            set_op(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom), 1'($urandom), $urandom, $urandom, 3'($urandom), 5'($urandom));
            in_valid_i = ($urandom % 4) != 0;
            set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            out_ready_i = ($urandom % 3) != 0;
            if (in_valid_i && in_ready_o) sent++;
            cyc++;
            @(negedge clk);
        end
        chk("stream_sent", sent, 32'd100);

        in_valid_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        out_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("stream_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts decoded ops from decode over a valid/ready handshake and buffers them in a 2-entry skid register.
- Selects ALU operands (rs1/PC, rs2/imm) and patches register operands with write-back results.
- Presents a_o/b_o/alu_op_o to the ALU with a registered valid; gives full throughput with a registered in_ready_o.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- in_valid_i  in  1  decode presents an op
- in_ready_o  out  1  stage can accept; registered
- in_rs1_i  in  REG_AW  rs1 index
- in_rs2_i  in  REG_AW  rs2 index
- in_rs1_val_i  in  XLEN  register-file read of rs1
- in_rs2_val_i  in  XLEN  register-file read of rs2
- in_pc_i  in  XLEN  instruction PC
- in_imm_i  in  XLEN  sign-extended immediate
- in_a_sel_i  in  1  0 = rs1 value, 1 = PC
- in_b_sel_i  in  1  0 = rs2 value, 1 = imm
- in_alu_op_i  in  3  ALU op code (ADD=000 … SRA=111)
- in_rd_i  in  REG_AW  destination index
- wb_we_i  in  1  write-back write enable
- wb_rd_i  in  REG_AW  write-back destination
- wb_data_i  in  XLEN  write-back data
- flush_i  in  1  kill all buffered ops
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  consumer accepts head
- a_o  out  XLEN  ALU operand A
- b_o  out  XLEN  ALU operand B
- alu_op_o  out  3  ALU op code
- rd_o  out  REG_AW  destination passthrough

Behaviour:
- Reset: both entries invalid. out_valid_o=0, in_ready_o=0 during the reset cycle and 1 from the first cycle after. a_o/b_o/alu_op_o/rd_o=0.
- Input accept when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
- Latency: op accepted in cycle N appears on out_valid_o in cycle N+1 if the head is empty or transferring.
- Entries: head (drives outputs) and skid.
- Accept while head empty or transferring: op goes to head.
- Accept while head valid and not transferring: op goes to skid.
- Transfer with skid valid: skid moves to head.
- in_ready_o = !skid_valid (registered next-state); never combinational from out_ready_i.
- Throughput: 1 op/cycle with out_ready_i held high. Order preserved; no drop, no duplicate.
- Each entry stores the 3-bit op, rd, a_sel, b_sel, rs1, rs2, and the resolved A/B values. A holds the rs1 value or PC; B holds the rs2 value or imm.
- Operand patch at capture: if wb_we_i and wb_rd_i != 0 and wb_rd_i == rs1 with a_sel=0, store wb_data_i instead of in_rs1_val_i. Same for rs2/b_sel.
- Operand patch while held: same match rule, evaluated every cycle, updates the stored value of every valid entry, including the head while stalled.
- x0 is never patched. PC/imm operands are never patched.
- A skid→head move and a write-back in the same cycle: the moved entry carries the patched value.
- Outputs a_o/b_o come straight from the head registers; no combinational path from wb_* to a_o/b_o.
- flush_i: both entries invalid next cycle and out_valid_o=0. An input accepted in the same cycle is dropped. in_ready_o=1 next cycle.
- flush_i and reset have priority over all other updates.
- Reset mid-operation is equivalent to flush, plus in_ready_o=0 for that cycle.
- out_valid_o never drops without a transfer or flush.
- Head outputs are stable while stalled, except for write-back patches.

Optional Feature:
- Macro: ALU_ISSUE_WB_PATCH_EN
- Defined: write-back patching as above.
- Undefined: all patch logic removed; wb_* ports remain but are ignored. Operands are stored exactly as read at capture. Decode must then stall on RAW hazards itself.

Decomposition:
- Shared package nano_rv32i_pkg: XLEN, REG_AW, ALU op encodings (ALU_ADD…ALU_SRA), A_SEL_RS1/A_SEL_PC and B_SEL_RS2/B_SEL_IMM constants, and the issue_entry_t typedef (valid, op, rd, rs1, rs2, a_sel, b_sel, a, b).
- One sub-module: issue_operand_patch. It takes an entry plus the wb_* signals and returns the patched entry. It is instantiated for capture, head and skid.

Test Plan:
- Single op, ADD, rs1=3 (val 5), rs2=4 (val 7), out_ready_i=1 → next cycle out_valid_o=1, a_o=5, b_o=7, alu_op_o=000; one cycle later out_valid_o=0.
- out_ready_i=0, push ops X then Y → in_ready_o=0 after Y. Release ready → X, then Y, on consecutive cycles; in_ready_o=1 once skid empties.
- Head stalled with rs1=6 (val 1); wb_we_i=1, wb_rd_i=6, wb_data_i=0xDEAD → next cycle a_o=0xDEAD. With the macro undefined, a_o stays 1.
- Capture-cycle patch: rs2=0 with wb_rd_i=0, wb_data_i=9 → b_o=rs2 value (x0 never patched). Same cycle, b_sel=1, imm=0xFFFFFFF0 with wb matching rs2 → b_o=0xFFFFFFF0.
- Both entries full, flush_i=1 together with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, no op emerges later.
- Stream 100 random ops with random out_ready_i → output sequence equals input sequence with patches applied; no loss or duplication.
